hazard_ctrl_unit: RTL and testbench

- Parametrised successor to the single-cycle load-use hazard detector for the 5-stage pipeline.
- Sits beside the IF/ID and ID/EX buffers and drives PC enable, buffer stall/flush and forwarding selects.
- Adds three things over the single-cycle detector: multi-cycle load-use bubbles, branch-taken flush, and a drain-then-halt sequence.
- Uses a small FSM with a down-counter.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_fwd_sel.sv | 37 +++
 rtl/hazard_ctrl_unit.sv | 183 ++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg                                                           |
// | Shared FSM encodings, forwarding selects and counter width for the   |
// | pipeline hazard controller.                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_fwd_sel                                                       |
// | Forwarding source select for one ALU operand; EX/MEM wins over       |
// | MEM/WB, register 0 never forwards.                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int RA_W = 4
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic            exmem_reg_write_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic            memwb_reg_write_i,
  output logic [1:0]      sel_o
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
  assign w_memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

  always_comb begin
    sel_o = FWD_REG;
    if (w_exmem_hit) begin
      sel_o = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl_unit                                                     |
// | Load-use bubbles, branch flush, drain-then-halt and operand          |
// | forwarding for the 5-stage pipeline. HAZARD_FWD_EN enables           |
// | forwarding; without it every RAW on a live writer stalls one cycle.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int               RA_W         = 4,
  parameter int               OPC_W        = 4,
  parameter logic [OPC_W-1:0] HALT_OPC     = 4'b1111,
  parameter int               LU_STALL     = 1,
  parameter int               DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] ifid_opc,
  input  logic [RA_W-1:0]  ifid_rs1,
  input  logic [RA_W-1:0]  ifid_rs2,
  input  logic [RA_W-1:0]  idex_rs1,
  input  logic [RA_W-1:0]  idex_rs2,
  input  logic [RA_W-1:0]  idex_rd,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic             memwb_reg_write,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             pc_halt,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic w_lu;
  logic w_hazard;

  // A zero source register never matches, so one live source is enough.
  assign w_lu = idex_mem_read &&
                (((ifid_rs1 != '0) && (ifid_rs1 == idex_rd)) ||
                 ((ifid_rs2 != '0) && (ifid_rs2 == idex_rd)));

`ifdef HAZARD_FWD_EN
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_unused;

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .rs_i              (idex_rs1),
    .exmem_rd_i        (exmem_rd),
    .exmem_reg_write_i (exmem_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_reg_write_i (memwb_reg_write),
    .sel_o             (w_fwd_a)
  );

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .rs_i              (idex_rs2),
    .exmem_rd_i        (exmem_rd),
    .exmem_reg_write_i (exmem_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_reg_write_i (memwb_reg_write),
    .sel_o             (w_fwd_b)
  );

  assign w_hazard = w_lu;
  assign fwd_a    = rst ? FWD_REG : w_fwd_a;
  assign fwd_b    = rst ? FWD_REG : w_fwd_b;
  assign w_unused = &{1'b0, idex_reg_write};
`else
  logic w_raw;
  logic w_unused;

  assign w_raw = ((ifid_rs1 != '0) &&
                  ((idex_reg_write && (ifid_rs1 == idex_rd)) ||
                   (exmem_reg_write && (ifid_rs1 == exmem_rd)))) ||
                 ((ifid_rs2 != '0) &&
                  ((idex_reg_write && (ifid_rs2 == idex_rd)) ||
                   (exmem_reg_write && (ifid_rs2 == exmem_rd))));

  assign w_hazard = w_lu | w_raw;
  assign fwd_a    = FWD_REG;
  assign fwd_b    = FWD_REG;
  assign w_unused = &{1'b0, idex_rs1, idex_rs2, memwb_rd, memwb_reg_write};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b0;
    pc_halt    = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          pc_en      = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_hazard) begin
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          // Only a load-use bubble is stretched; a RAW stall is re-evaluated next cycle.
          if (w_lu && (LU_STALL > 1)) begin
            state_d = STALL;
            cnt_d   = CNT_W'(LU_STALL - 1);
          end
        end else if (ifid_opc == HALT_OPC) begin
          ifid_flush = 1'b1;
          state_d    = DRAIN;
          cnt_d      = CNT_W'(DRAIN_CYCLES);
        end else begin
          pc_en = 1'b1;
        end
      end
      STALL: begin
        if (branch_taken) begin
          pc_en      = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = RUN;
          cnt_d      = '0;
        end else begin
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      DRAIN: begin
        // Halt is already committed here, so branch_taken has no effect.
        ifid_flush = 1'b1;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          pc_halt = 1'b1;
          state_d = HALT;
        end
      end
      HALT: begin
        pc_halt    = 1'b1;
        ifid_flush = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (rst) begin
      pc_en      = 1'b0;
      pc_halt    = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl_unit                                                  |
// | Directed bench for hazard_ctrl_unit with LU_STALL=1 and LU_STALL=3   |
// | instances against a cycle-indexed model. Honours HAZARD_FWD_EN.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl_unit;

  localparam int         DRAIN = 3;
  localparam logic [3:0] HOPC  = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ifid_opc, ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_mem_read, idex_reg_write, exmem_reg_write, memwb_reg_write, branch_taken;

  logic       a_pc_en, a_pc_halt, a_ifid_stall, a_ifid_flush, a_idex_flush;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic       b_pc_en, b_pc_halt, b_ifid_stall, b_ifid_flush, b_idex_flush;
  logic [1:0] b_fwd_a, b_fwd_b;
  logic [8:0] o1, o3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.RA_W(4), .OPC_W(4), .HALT_OPC(HOPC), .LU_STALL(1), .DRAIN_CYCLES(DRAIN)) u_l1 (
    .clk(clk), .rst(rst), .ifid_opc(ifid_opc), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .branch_taken(branch_taken),
    .pc_en(a_pc_en), .pc_halt(a_pc_halt), .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush),
    .idex_flush(a_idex_flush), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b)
  );

  hazard_ctrl_unit #(.RA_W(4), .OPC_W(4), .HALT_OPC(HOPC), .LU_STALL(3), .DRAIN_CYCLES(DRAIN)) u_l3 (
    .clk(clk), .rst(rst), .ifid_opc(ifid_opc), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .branch_taken(branch_taken),
    .pc_en(b_pc_en), .pc_halt(b_pc_halt), .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush),
    .idex_flush(b_idex_flush), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b)
  );

  // {pc_en, pc_halt, ifid_stall, ifid_flush, idex_flush, fwd_a, fwd_b}
  assign o1 = {a_pc_en, a_pc_halt, a_ifid_stall, a_ifid_flush, a_idex_flush, a_fwd_a, a_fwd_b};
  assign o3 = {b_pc_en, b_pc_halt, b_ifid_stall, b_ifid_flush, b_idex_flush, b_fwd_a, b_fwd_b};

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // A nonzero register that one of the IF/ID sources reads.
  function automatic logic reads(input logic [3:0] r);
    return (r != 4'd0) && ((r == ifid_rs1) || (r == ifid_rs2));
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_of(input logic [3:0] rs);
    if (rs != 4'd0 && exmem_reg_write && exmem_rd == rs) return 2'b10;
    if (rs != 4'd0 && memwb_reg_write && memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction
`endif

  // Model: cycle index t, per-instance "stalled until cycle" and "halt seen at cycle".
  int t = 0;
  int stall_until [2];
  int halt_at [2];

  always @(negedge clk) begin : model
    logic       pe, ph, st, ff, xf, lu, hz;
    logic [1:0] fa, fb;
    int         len;
    for (int k = 0; k < 2; k++) begin
      len = (k == 0) ? 1 : 3;
      pe = 0; ph = 0; st = 0; ff = 0; xf = 0; fa = 2'b00; fb = 2'b00;
      lu = idex_mem_read && reads(idex_rd);
      hz = lu;
`ifndef HAZARD_FWD_EN
      hz = hz || (idex_reg_write && reads(idex_rd)) || (exmem_reg_write && reads(exmem_rd));
`endif
      if (rst) begin
        stall_until[k] = 0;
        halt_at[k]     = -1;
      end else begin
`ifdef HAZARD_FWD_EN
        fa = fwd_of(idex_rs1);
        fb = fwd_of(idex_rs2);
`endif
        if (halt_at[k] >= 0) begin
          ff = 1;
          ph = (t - halt_at[k]) >= DRAIN;
        end else if (branch_taken) begin
          pe = 1; ff = 1; xf = 1;
          stall_until[k] = 0;
        end else if (t < stall_until[k] || hz) begin
          st = 1; xf = 1;
          if (t >= stall_until[k] && lu) stall_until[k] = t + len;
        end else if (ifid_opc == HOPC) begin
          ff = 1;
          halt_at[k] = t;
        end else begin
          pe = 1;
        end
      end
      chk((k == 0) ? "model_l1" : "model_l3", (k == 0) ? o1 : o3, {pe, ph, st, ff, xf, fa, fb});
    end
    t++;
  end

  task automatic clr();
    ifid_opc = 0; ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0;
    exmem_rd = 0; memwb_rd = 0; idex_mem_read = 0; idex_reg_write = 0;
    exmem_reg_write = 0; memwb_reg_write = 0; branch_taken = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    look(); chk("rst_l1", o1, 9'h000); chk("rst_l3", o3, 9'h000);
    cyc(); look();
    cyc(); rst = 1'b0;
    look(); chk("idle", o1, 9'h100);

    // Load-use held for one cycle
    cyc(); idex_mem_read = 1; idex_rd = 3; ifid_rs1 = 3;
    look(); chk("lu1_c0", o1, 9'h050); chk("lu3_c0", o3, 9'h050);
    cyc(); clr();
    look(); chk("lu1_c1", o1, 9'h100); chk("lu3_c1", o3, 9'h050);
    cyc(); look(); chk("lu3_c2", o3, 9'h050);
    cyc(); look(); chk("lu3_c3", o3, 9'h100);

    // Branch beats load-use, no STALL entry
    cyc(); idex_mem_read = 1; idex_rd = 3; ifid_rs1 = 3; branch_taken = 1;
    look(); chk("br_lu1", o1, 9'h130); chk("br_lu3", o3, 9'h130);
    cyc(); clr();
    look(); chk("br_nostall", o3, 9'h100);

    // Branch during STALL cancels the remaining bubbles
    cyc(); idex_mem_read = 1; idex_rd = 3; ifid_rs2 = 3;
    look(); chk("lu_rs2", o3, 9'h050);
    cyc(); clr(); branch_taken = 1;
    look(); chk("br_in_stall", o3, 9'h130);
    cyc(); clr();
    look(); chk("after_br_stall", o3, 9'h100);

    // Register 0 never hazards
    cyc(); idex_mem_read = 1; idex_reg_write = 1;
    look(); chk("lu_r0", o3, 9'h100);

    // RAW on non-load writers / forwarding
    cyc(); clr(); idex_reg_write = 1; idex_rd = 7; ifid_rs2 = 7;
`ifdef HAZARD_FWD_EN
    look(); chk("raw_idex", o3, 9'h100);
`else
    look(); chk("raw_idex", o3, 9'h050);
`endif
    cyc(); clr();
    look(); chk("raw_no_ext", o3, 9'h100);
    cyc(); exmem_reg_write = 1; exmem_rd = 4; ifid_rs1 = 4;
`ifdef HAZARD_FWD_EN
    look(); chk("raw_exmem", o1, 9'h100);
`else
    look(); chk("raw_exmem", o1, 9'h050);
`endif
    cyc(); clr(); memwb_reg_write = 1; memwb_rd = 6; ifid_rs1 = 6;
    look(); chk("raw_memwb", o1, 9'h100);
    cyc(); clr(); exmem_rd = 5; exmem_reg_write = 1; memwb_rd = 5; memwb_reg_write = 1; idex_rs1 = 5;
`ifdef HAZARD_FWD_EN
    look(); chk("fwd_exmem", o1, 9'h108);
    cyc(); exmem_reg_write = 0;
    look(); chk("fwd_memwb", o1, 9'h104);
    cyc(); exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    look(); chk("fwd_r0", o1, 9'h100);
    cyc(); exmem_reg_write = 0; memwb_rd = 9; idex_rs1 = 0; idex_rs2 = 9;
    look(); chk("fwd_b_memwb", o3, 9'h101);
`else
    look(); chk("fwd_tied", o1, 9'h100);
`endif

    // Halt sequence; branch during DRAIN is ignored
    cyc(); clr(); ifid_opc = HOPC;
    look(); chk("halt_c0", o1, 9'h020);
    cyc(); ifid_opc = 0; branch_taken = 1;
    look(); chk("drain_c1_br", o1, 9'h020);
    cyc(); branch_taken = 0;
    look(); chk("drain_c2", o3, 9'h020);
    cyc(); look(); chk("halt_c3", o1, 9'h0A0);
    repeat (3) begin cyc(); look(); end
    chk("halt_sticky", o3, 9'h0A0);

    // Reset in the middle of DRAIN
    cyc(); rst = 1;
    look(); chk("rst_halted", o1, 9'h000);
    cyc(); rst = 0; ifid_opc = HOPC;
    look(); chk("halt2_c0", o3, 9'h020);
    cyc(); ifid_opc = 0;
    look();
    cyc(); rst = 1;
    look(); chk("rst_mid_drain", o1, 9'h000);
    cyc(); rst = 0;
    look(); chk("run_after_rst", o1, 9'h100);
    cyc(); look();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
